// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver states and a parity helper.
// Pure declarations; no latency and no flow control.
package uart_pkg;

    localparam int PAR_NONE  = 0;
    localparam int PAR_ODD   = 1;
    localparam int PAR_EVEN  = 2;

    // Widest vector the parity helper accepts; narrower words are zero-extended.
    localparam int PAR_MAX_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Received-word channel: data plus error flags under a valid/ready handshake.
// The master holds rx_valid and the word until the slave raises rx_ready.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer with a selectable reset value; output lags input by 2 clk.
// No handshake: the input is sampled every clock.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver; word appears 1 clk after the final stop-bit sample.
// Single-entry output register: a frame completing while it is still held is dropped and flagged by overrun.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             rx,
    output logic             busy,
    uart_rx_param_if.master  out
);

    localparam int              CW       = $clog2(OVERSAMPLE);
    localparam int              IW       = $clog2(DATA_BITS);
    localparam logic [CW-1:0]   CNT_HALF = CW'(OVERSAMPLE/2 - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0]   IDX_LAST = IW'(DATA_BITS - 1);

    logic                 rxs;
    rx_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 perr_acc_q;
    logic                 ferr_acc_q;
    logic                 busy_q;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 ovr_q;

    logic samp_mid;
    logic samp_end;
    logic par_bad;
    logic ferr_next;
    logic stop_last;
    logic out_free;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rxs)
    );

    assign samp_mid  = tick && (cnt_q == CNT_HALF);
    assign samp_end  = tick && (cnt_q == CNT_LAST);
    assign ferr_next = ferr_acc_q | ~rxs;
    assign stop_last = (STOP_BITS == 1) || stop_idx_q;
    // A held word leaving this very cycle frees the slot for the new one.
    assign out_free  = ~valid_q | out.rx_ready;

    always_comb begin
        par_bad = 1'b0;
        if (PARITY == PAR_ODD) begin
            par_bad = ~(calc_parity(PAR_MAX_W'(shift_q)) ^ rxs);
        end else if (PARITY == PAR_EVEN) begin
            par_bad = calc_parity(PAR_MAX_W'(shift_q)) ^ rxs;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            busy_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (valid_q && out.rx_ready) begin
                valid_q <= 1'b0;
            end
            if (tick) begin
                cnt_q <= cnt_q + CW'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    cnt_q      <= '0;
                    stop_idx_q <= 1'b0;
                    perr_acc_q <= 1'b0;
                    ferr_acc_q <= 1'b0;
                    if (!rxs) begin
                        state_q <= ST_START;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (samp_mid) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (rxs) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (samp_end) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
                        idx_q   <= idx_q + IW'(1);
                        if (idx_q == IDX_LAST) begin
                            state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (samp_end) begin
                        cnt_q      <= '0;
                        perr_acc_q <= par_bad;
                        state_q    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (samp_end) begin
                        cnt_q      <= '0;
                        ferr_acc_q <= ferr_next;
                        stop_idx_q <= 1'b1;
                        if (stop_last) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            if (out_free) begin
                                data_q  <= shift_q;
                                perr_q  <= perr_acc_q;
                                ferr_q  <= ferr_next;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign out.rx_data    = data_q;
    assign out.rx_valid   = valid_q;
    assign out.parity_err = perr_q;
    assign out.frame_err  = ferr_q;
    assign out.overrun    = ovr_q;

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the serial front end of the design. It is the next-generation replacement for the fixed 8N1 receiver. It oversamples a tick-qualified serial line and supports configurable data width, parity, stop-bit count, start-glitch rejection and error reporting. Received words go to downstream logic through a single-entry valid/ready output register.

## Interface
- DATA_BITS, 8, data bits per frame, legal 5..9
- OVERSAMPLE, 16, ticks per bit, legal 8..32, even
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, legal 1 or 2
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- tick  in  1  baud-oversample strobe, one clk wide, OVERSAMPLE per bit
- rx  in  1  asynchronous serial line, idle high
- rx_data  out  DATA_BITS  received word, LSB first on the line
- rx_valid  out  1  rx_data and error flags valid
- rx_ready  in  1  consumer accepts word
- parity_err  out  1  parity mismatch on held word; constant 0 when PARITY = 0
- frame_err  out  1  any stop bit sampled low on held word
- overrun  out  1  one-clk pulse, completed frame dropped
- busy  out  1  high in any state except IDLE

## Operation
- rx passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized line rxs.
- The tick counter cnt is $clog2(OVERSAMPLE) bits wide and advances only on tick.
- States and transitions:
  - IDLE: if rxs = 0, go to START with cnt = 0.
  - START: on the tick where cnt = OVERSAMPLE/2-1, check rxs:
    - rxs = 0: go to DATA with cnt = 0 and bit index = 0.
    - rxs = 1 (glitch): return to IDLE; nothing is delivered.
  - DATA: on the tick where cnt = OVERSAMPLE-1, shift rxs into the shift register MSB (right-shift, LSB first) and reset cnt to 0. After DATA_BITS samples, go to PARITY if PARITY != 0, otherwise STOP.
  - PARITY: one sample at bit centre. Error if XOR(data, sample) = 0 for odd parity or 1 for even parity.
  - STOP: one sample per stop bit at bit centre. Any low sample sets the frame error. After the last stop sample, deliver the frame and return to IDLE immediately. A new start edge is accepted from the next clk, which allows back-to-back frames.
- Delivery:
  - If the output register is empty, or is being transferred this cycle (rx_valid & rx_ready), load rx_data and both error flags, and set rx_valid.
  - Otherwise keep the old word, discard the new one, and pulse overrun.
- Frames with errors are still delivered, with their flags set.
- rx_valid clears on rx_valid & rx_ready unless a new word loads in the same cycle.
- Reset, asynchronous at any point including mid-frame:
  - state = IDLE, cnt = 0, shift register = 0.
  - rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0.
  - After reset release, a partially received frame is never delivered.

## Timing
- rx edge reaches rxs after 2 clk.
- Each sample is taken on the clk edge where tick is high and cnt is at its terminal value.
- rx_valid, rx_data and the error flags update 1 clk after the tick that samples the final stop bit.
- overrun pulses in that same cycle.
- rx_valid stays high until accepted; it needs no tick.
- If tick is held low, state is frozen (no timeout).
- Simultaneous delivery and acceptance: the new word is visible on the next clk with rx_valid still high, and overrun = 0.

## Structure
- Shared package uart_pkg:
  - parity-mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - rx state enum (IDLE, START, DATA, PARITY, STOP);
  - helper function computing parity over a width-generic vector.
- Sub-module uart_sync2: a generic 2-flop synchronizer with parametrised reset value, reused later by the transmitter's CTS input.
- All remaining logic (FSM, counters, shift register, output register) stays in one module.

## Test plan
- Defaults, OVERSAMPLE = 16: send 8N1 0xA5 with rx_ready = 1 -> rx_data = 0xA5, rx_valid high 1 clk, both error flags 0.
- PARITY = 2, DATA_BITS = 7: send 0x41 with parity bit 1 (wrong; correct is 0) -> rx_data = 0x41, parity_err = 1. Resend with parity 0 -> parity_err = 0.
- STOP_BITS = 2: second stop bit driven low -> frame_err = 1. Following frame 0x3C with valid stop bits -> frame_err = 0.
- Start glitch: rx low for 4 ticks, then high -> no rx_valid, busy returns low, and the next real frame 0x81 is received correctly.
- Overrun: rx_ready = 0, send 0x11 then 0x22 back-to-back -> overrun pulses once and rx_data stays 0x11. Raise rx_ready -> 0x11 accepted, then rx_valid = 0.
- Reset mid-frame: assert rst after 3 data bits -> all outputs 0 at once. Release, send 0x5A -> only 0x5A is delivered.
